instr_cache_refill: RTL and testbench

- Upstream producer for the instruction cache data array and tag array.
- Accepts one miss request (line physical address plus victim way) and issues a single line-aligned read to the memory bus.
- Assembles the returned beats into a full line, then writes data and tag in one cycle.
- Blocking: one refill in flight; fetch stalls on o_busy.

---
 rtl/instr_cache_refill_pkg.sv | 18 +
 rtl/instr_cache_line_buffer.sv | 41 ++++
 rtl/instr_cache_refill.sv | 145 ++++++++++++++
 tb/tb_instr_cache_refill.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_refill_pkg.sv
// Shared types and default geometry for the instruction cache refill path.
package instr_cache_refill_pkg;

  localparam int unsigned ICACHE_LINE_BYTES = 32;
  localparam int unsigned ICACHE_BUS_BYTES  = 8;
  localparam int unsigned ICACHE_SETS       = 64;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StWrite,
    StErr
  } icache_refill_state_t;

  typedef logic [ICACHE_LINE_BYTES*8-1:0] icache_line_t;

endpackage

// File: rtl/instr_cache_line_buffer.sv
// Line assembly buffer: stores response beats into consecutive slots, lowest bytes first.
module instr_cache_line_buffer #(
  parameter int unsigned LINE_BYTES = instr_cache_refill_pkg::ICACHE_LINE_BYTES,
  parameter int unsigned BUS_BYTES  = instr_cache_refill_pkg::ICACHE_BUS_BYTES,
  localparam int unsigned BEATS     = LINE_BYTES / BUS_BYTES,
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [BUS_BYTES*8-1:0]  beat,
  output logic [LINE_BYTES*8-1:0] line,
  output logic [CNT_W-1:0]        count,
  output logic                    full
);
  import instr_cache_refill_pkg::*;

  localparam int unsigned     BusW     = BUS_BYTES * 8;
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]        count_q;
  logic [LINE_BYTES*8-1:0] line_q;

  // Slot write and beat counter; counter wraps after the last slot.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      line_q  <= '0;
    end else if (accept) begin
      line_q[count_q*BusW +: BusW] <= beat;
      count_q <= (count_q == LastBeat) ? '0 : count_q + 1'b1;
    end
  end

  assign line  = line_q;
  assign count = count_q;
  // High while the next accepted beat lands in the final slot.
  assign full  = (count_q == LastBeat);

endmodule

// File: rtl/instr_cache_refill.sv
// Blocking instruction cache refill engine: one miss -> one line read -> one array write.
module instr_cache_refill #(
  parameter int unsigned PADDR_WIDTH  = 32,
  parameter int unsigned ICACHE_ASSOC = 4,
  parameter int unsigned ICACHE_SETS  = instr_cache_refill_pkg::ICACHE_SETS,
  parameter int unsigned LINE_BYTES   = instr_cache_refill_pkg::ICACHE_LINE_BYTES,
  parameter int unsigned BUS_BYTES    = instr_cache_refill_pkg::ICACHE_BUS_BYTES,
  localparam int unsigned OFS_W       = $clog2(LINE_BYTES),
  localparam int unsigned IDX_W       = $clog2(ICACHE_SETS),
  localparam int unsigned TAG_W       = PADDR_WIDTH - IDX_W - OFS_W,
  localparam int unsigned WAY_W       = $clog2(ICACHE_ASSOC)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_miss_valid,
  input  logic [PADDR_WIDTH-1:0]  i_miss_paddr,
  input  logic [WAY_W-1:0]        i_miss_way,
  output logic                    o_miss_ready,
  output logic                    o_mem_req_valid,
  output logic [PADDR_WIDTH-1:0]  o_mem_req_paddr,
  input  logic                    i_mem_req_ready,
  input  logic                    i_mem_resp_valid,
  input  logic [BUS_BYTES*8-1:0]  i_mem_resp_data,
  input  logic                    i_mem_resp_last,
  input  logic                    i_mem_resp_err,
  output logic                    o_mem_resp_ready,
  output logic                    o_data_wr_en,
  output logic [WAY_W-1:0]        o_data_wr_way,
  output logic [IDX_W-1:0]        o_data_wr_set,
  output logic [LINE_BYTES*8-1:0] o_data_wr_line,
  output logic [TAG_W-1:0]        o_tag_wr_tag,
  output logic                    o_busy,
  output logic                    o_refill_err
);
  import instr_cache_refill_pkg::*;

  localparam int unsigned BEATS = LINE_BYTES / BUS_BYTES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]       LastBeat = CNT_W'(BEATS - 1);
  localparam logic [PADDR_WIDTH-1:0] OfsMask  = PADDR_WIDTH'((64'd1 << OFS_W) - 64'd1);

  icache_refill_state_t   state_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic [WAY_W-1:0]       way_q;
  logic                   miss_ready_q, req_valid_q, resp_ready_q;
  logic                   wr_en_q, err_q, busy_q;

  logic             buf_clear, beat_accept, buf_full, beat_bad;
  logic [CNT_W-1:0] beat_count;

  assign buf_clear   = (state_q == StReq) && i_mem_req_ready;
  assign beat_accept = i_mem_resp_valid && resp_ready_q;
  // Bus error, last flagged before the final slot, or final slot without last.
  assign beat_bad    = i_mem_resp_err
                     | (i_mem_resp_last & (beat_count != LastBeat))
                     | (buf_full & ~i_mem_resp_last);

  instr_cache_line_buffer #(
    .LINE_BYTES(LINE_BYTES),
    .BUS_BYTES (BUS_BYTES)
  ) u_line_buffer (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (buf_clear),
    .accept(beat_accept),
    .beat  (i_mem_resp_data),
    .line  (o_data_wr_line),
    .count (beat_count),
    .full  (buf_full)
  );

  // Refill sequencer; handshake and strobe outputs are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      paddr_q      <= '0;
      way_q        <= '0;
      miss_ready_q <= 1'b1;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_miss_valid) begin
            state_q      <= StReq;
            paddr_q      <= i_miss_paddr & ~OfsMask;
            way_q        <= i_miss_way;
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            req_valid_q  <= 1'b1;
          end
        end
        StReq: begin
          if (i_mem_req_ready) begin
            state_q      <= StFill;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        StFill: begin
          if (beat_accept) begin
            if (beat_bad) begin
              state_q      <= StErr;
              resp_ready_q <= 1'b0;
              err_q        <= 1'b1;
            end else if (i_mem_resp_last) begin
              state_q      <= StWrite;
              resp_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
            end
          end
        end
        StWrite, StErr: begin
          state_q      <= StIdle;
          miss_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          miss_ready_q <= 1'b1;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign o_miss_ready     = miss_ready_q;
  assign o_mem_req_valid  = req_valid_q;
  assign o_mem_req_paddr  = paddr_q;
  assign o_mem_resp_ready = resp_ready_q;
  assign o_data_wr_en     = wr_en_q;
  assign o_data_wr_way    = way_q;
  assign o_data_wr_set    = paddr_q[OFS_W +: IDX_W];
  assign o_tag_wr_tag     = paddr_q[PADDR_WIDTH-1 -: TAG_W];
  assign o_busy           = busy_q;
  assign o_refill_err     = err_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Scoreboard bench for instr_cache_refill: driver pushes expectations, monitor checks outputs.
module tb_instr_cache_refill;
  localparam int PW    = 32;
  localparam int ASSOC = 4;
  localparam int SETS  = 64;
  localparam int LB    = 32;
  localparam int BB    = 8;
  localparam int BEATS = LB / BB;
  localparam int LW    = LB * 8;
  localparam int BW    = BB * 8;
  localparam int IDXW  = 6;
  localparam int TAGW  = 21;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_miss_valid;
  logic [PW-1:0] i_miss_paddr;
  logic [1:0]    i_miss_way;
  logic          o_miss_ready;
  logic          o_mem_req_valid;
  logic [PW-1:0] o_mem_req_paddr;
  logic          i_mem_req_ready;
  logic          i_mem_resp_valid;
  logic [BW-1:0] i_mem_resp_data;
  logic          i_mem_resp_last;
  logic          i_mem_resp_err;
  logic          o_mem_resp_ready;
  logic          o_data_wr_en;
  logic [1:0]    o_data_wr_way;
  logic [IDXW-1:0] o_data_wr_set;
  logic [LW-1:0] o_data_wr_line;
  logic [TAGW-1:0] o_tag_wr_tag;
  logic          o_busy;
  logic          o_refill_err;

  always #5 clk = ~clk;

  instr_cache_refill #(
    .PADDR_WIDTH (PW),
    .ICACHE_ASSOC(ASSOC),
    .ICACHE_SETS (SETS),
    .LINE_BYTES  (LB),
    .BUS_BYTES   (BB)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_miss_valid    (i_miss_valid),
    .i_miss_paddr    (i_miss_paddr),
    .i_miss_way      (i_miss_way),
    .o_miss_ready    (o_miss_ready),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_paddr (o_mem_req_paddr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_resp_valid(i_mem_resp_valid),
    .i_mem_resp_data (i_mem_resp_data),
    .i_mem_resp_last (i_mem_resp_last),
    .i_mem_resp_err  (i_mem_resp_err),
    .o_mem_resp_ready(o_mem_resp_ready),
    .o_data_wr_en    (o_data_wr_en),
    .o_data_wr_way   (o_data_wr_way),
    .o_data_wr_set   (o_data_wr_set),
    .o_data_wr_line  (o_data_wr_line),
    .o_tag_wr_tag    (o_tag_wr_tag),
    .o_busy          (o_busy),
    .o_refill_err    (o_refill_err)
  );

  typedef struct {
    bit              is_err;
    logic [1:0]      way;
    logic [IDXW-1:0] set;
    logic [TAGW-1:0] tag;
    logic [LW-1:0]   line;
  } res_t;

  res_t          res_q[$];
  logic [PW-1:0] req_q[$];
  res_t          mres;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string nm);
    fail_now({"timeout_", nm});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench stopped");
  endtask

  // Monitor: pops expectations whenever the DUT presents a request or result.
  always @(negedge clk) begin
    if (!i_rst) begin
      chk("busy_vs_ready", o_busy, !o_miss_ready);
      if (o_mem_req_valid || o_miss_ready) chk("resp_ready_off", o_mem_resp_ready, 1'b0);
      if (o_mem_req_valid) begin
        if (req_q.size() == 0) fail_now("unexpected_req");
        else begin
          chk("req_paddr", o_mem_req_paddr, req_q[0]);
          if (i_mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (o_data_wr_en || o_refill_err) begin
        if (res_q.size() == 0) fail_now("unexpected_result_pulse");
        else begin
          mres = res_q.pop_front();
          wr_cyc = cyc;
          chk("refill_err", o_refill_err, mres.is_err);
          chk("wr_en", o_data_wr_en, !mres.is_err);
          if (!mres.is_err) begin
            chk("wr_way", o_data_wr_way, mres.way);
            chk("wr_set", o_data_wr_set, mres.set);
            chk("wr_tag", o_tag_wr_tag, mres.tag);
            chk("wr_line", o_data_wr_line, mres.line);
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, o_busy, 1'b0);
    chk({pfx, "_miss_ready"}, o_miss_ready, 1'b1);
    chk({pfx, "_req_valid"}, o_mem_req_valid, 1'b0);
    chk({pfx, "_resp_ready"}, o_mem_resp_ready, 1'b0);
    chk({pfx, "_wr_en"}, o_data_wr_en, 1'b0);
    chk({pfx, "_err"}, o_refill_err, 1'b0);
    chk({pfx, "_req_paddr"}, o_mem_req_paddr, '0);
    chk({pfx, "_wr_way"}, o_data_wr_way, '0);
    chk({pfx, "_wr_set"}, o_data_wr_set, '0);
    chk({pfx, "_wr_tag"}, o_tag_wr_tag, '0);
    chk({pfx, "_wr_line"}, o_data_wr_line, '0);
  endtask

  // kind: 0 normal, 1 bus error on beat kb, 2 early last on beat kb, 3 late last.
  task automatic run_txn(input logic [PW-1:0] pa, input logic [1:0] way, input int kind,
                         input int kb, input int req_wait, input bit gaps, input bit directed,
                         input int rst_at, input bit timing);
    logic [BW-1:0] beats[BEATS];
    logic [LW-1:0] line;
    logic [7:0]    b;
    res_t          r;
    int            acc_cyc, t, nb;
    bit            go;
    line = '0;
    for (int i = 0; i < BEATS; i++) begin
      b = 8'((i + 1) * 17);
      beats[i] = directed ? {8{b}} : {$urandom, $urandom};
      line = line | ({{(LW-BW){1'b0}}, beats[i]} << (BW * i));
    end
    r.is_err = (kind != 0);
    r.way    = way;
    r.set    = IDXW'((pa / LB) % SETS);
    r.tag    = TAGW'(pa / (LB * SETS));
    r.line   = line;
    // Stray beat while idle must be backpressured.
    if (!directed) begin
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = {$urandom, $urandom};
      step();
      i_mem_resp_valid = 1'b0;
    end
    i_miss_valid = 1'b1;
    i_miss_paddr = pa;
    i_miss_way   = way;
    req_q.push_back(pa & ~32'h1f);
    if (rst_at < 0) res_q.push_back(r);
    go = 1'b0;
    t  = 0;
    while (!go) begin
      go = o_miss_ready;
      step();
      if (++t > 50) timeout("miss_accept");
    end
    acc_cyc = cyc;
    // Second miss held while busy and stray beats during the request phase.
    i_miss_paddr     = $urandom;
    i_miss_way       = 2'($urandom);
    i_mem_resp_valid = (req_wait > 0);
    i_mem_resp_data  = {$urandom, $urandom};
    i_mem_req_ready  = 1'b0;
    go = 1'b0;
    t  = 0;
    while (!go) begin
      if (t >= req_wait) begin
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b0;
      end
      go = o_mem_req_valid && i_mem_req_ready;
      step();
      if (++t > 60) timeout("req_handshake");
    end
    i_mem_req_ready = 1'b0;
    i_miss_valid    = 1'b0;
    nb = (kind == 0 || kind == 3) ? BEATS : kb + 1;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        i_rst            = 1'b1;
        i_mem_resp_valid = 1'b0;
        step();
        i_rst = 1'b0;
        chk_reset_outputs("midrst");
        repeat (3) step();
        return;
      end
      if (gaps) repeat ($urandom_range(0, 2)) step();
      i_mem_resp_valid = 1'b1;
      i_mem_resp_data  = beats[i];
      i_mem_resp_last  = (kind == 0 || kind == 1) ? (i == BEATS - 1) : (kind == 2 && i == kb);
      i_mem_resp_err   = (kind == 1 && i == kb);
      t = 0;
      while (!o_mem_resp_ready) begin
        step();
        if (++t > 50) timeout("beat_accept");
      end
      step();
      i_mem_resp_valid = 1'b0;
      i_mem_resp_last  = 1'b0;
      i_mem_resp_err   = 1'b0;
    end
    t = 0;
    while (!o_miss_ready) begin
      step();
      if (++t > 50) timeout("return_idle");
    end
    if (timing) begin
      chk("wr_latency", 32'(wr_cyc - acc_cyc), BEATS + 1);
      chk("ready_latency", 32'(cyc - acc_cyc), BEATS + 2);
    end
  endtask

  initial begin
    int k;
    i_rst            = 1'b1;
    i_miss_valid     = 1'b0;
    i_miss_paddr     = '0;
    i_miss_way       = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_resp_valid = 1'b0;
    i_mem_resp_data  = '0;
    i_mem_resp_last  = 1'b0;
    i_mem_resp_err   = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    i_rst = 1'b0;
    step();

    run_txn(32'h0000_1234, 2'd2, 0, 0, 0, 1'b0, 1'b1, -1, 1'b1);
    run_txn($urandom, 2'd1, 0, 0, 5, 1'b0, 1'b0, -1, 1'b0);
    run_txn($urandom, 2'd3, 1, 2, 0, 1'b0, 1'b0, -1, 1'b0);
    run_txn($urandom, 2'd0, 0, 0, 0, 1'b0, 1'b1, -1, 1'b1);
    run_txn($urandom, 2'd1, 2, 1, 0, 1'b0, 1'b0, -1, 1'b0);
    run_txn($urandom, 2'd2, 3, 0, 0, 1'b0, 1'b0, -1, 1'b0);
    run_txn($urandom, 2'd3, 0, 0, 2, 1'b0, 1'b0, 2, 1'b0);
    run_txn($urandom, 2'd0, 0, 0, 0, 1'b0, 1'b0, -1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        6:       run_txn($urandom, 2'($urandom), 1, $urandom_range(0, 3), $urandom_range(0, 4),
                         1'b1, 1'b0, -1, 1'b0);
        7:       run_txn($urandom, 2'($urandom), 2, $urandom_range(0, 2), $urandom_range(0, 4),
                         1'b1, 1'b0, -1, 1'b0);
        8:       run_txn($urandom, 2'($urandom), 3, 0, $urandom_range(0, 4),
                         1'b1, 1'b0, -1, 1'b0);
        default: run_txn($urandom, 2'($urandom), 0, 0, $urandom_range(0, 4),
                         1'b1, 1'b0, -1, 1'b0);
      endcase
    end

    repeat (3) step();
    chk("req_queue_drained", 32'(req_q.size()), 0);
    chk("result_queue_drained", 32'(res_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
